// File: rtl/r5p_tcl_arbiter.sv
// Two-requester arbiter for the R5P TCL bus: fixed or round-robin priority,
// the grant is held while a request stalls, and responses are steered to the requester that issued them.

module r5p_tcl_arbiter_port #(
    parameter int unsigned IDX = 0
) (
    input  logic rst_i,
    input  logic gnt_i,
    input  logic m_rdy_i,
    input  logic m_err_i,
    input  logic rsp_vld_i,
    input  logic rsp_sel_i,
    output logic rdy_o,
    output logic err_o
);
    localparam logic SEL = IDX[0];

    assign rdy_o = ~rst_i & m_rdy_i & (gnt_i == SEL);
    assign err_o = ~rst_i & m_err_i & rsp_vld_i & (rsp_sel_i == SEL);
endmodule

module r5p_tcl_arbiter #(
    parameter logic ARB_RR = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s0_vld_i,
    input  logic        s0_wen_i,
    input  logic [31:0] s0_adr_i,
    input  logic [3:0]  s0_ben_i,
    input  logic [31:0] s0_wdt_i,
    output logic [31:0] s0_rdt_o,
    output logic        s0_err_o,
    output logic        s0_rdy_o,
    input  logic        s1_vld_i,
    input  logic        s1_wen_i,
    input  logic [31:0] s1_adr_i,
    input  logic [3:0]  s1_ben_i,
    input  logic [31:0] s1_wdt_i,
    output logic [31:0] s1_rdt_o,
    output logic        s1_err_o,
    output logic        s1_rdy_o,
    output logic        m_vld_o,
    output logic        m_wen_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_ben_o,
    output logic [31:0] m_wdt_o,
    input  logic [31:0] m_rdt_i,
    input  logic        m_err_i,
    input  logic        m_rdy_i
);
    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } req_t;

    localparam int unsigned NUM_REQ = 2;

    logic [NUM_REQ-1:0] vld;
    req_t               req [NUM_REQ];
    logic [NUM_REQ-1:0] rdy_w;
    logic [NUM_REQ-1:0] err_w;

    logic lck_vld_q, lck_vld_d;
    logic lck_sel_q, lck_sel_d;
    logic ptr_q, ptr_d;
    logic rsp_vld_q, rsp_vld_d;
    logic rsp_sel_q, rsp_sel_d;
    logic gnt;
    logic xfer;

    assign vld    = {s1_vld_i, s0_vld_i};
    assign req[0] = '{wen: s0_wen_i, adr: s0_adr_i, ben: s0_ben_i, wdt: s0_wdt_i};
    assign req[1] = '{wen: s1_wen_i, adr: s1_adr_i, ben: s1_ben_i, wdt: s1_wdt_i};

    // A stalled request keeps its grant regardless of what the other side raises.
    always_comb begin
        gnt = ptr_q;
        if (lck_vld_q) begin
            gnt = lck_sel_q;
        end else begin
            unique case (vld)
                2'b01:   gnt = 1'b0;
                2'b10:   gnt = 1'b1;
                2'b11:   gnt = ARB_RR ? ptr_q : 1'b0;
                default: gnt = ptr_q;
            endcase
        end
    end

    assign m_vld_o = ~rst_i & vld[gnt];
    assign m_wen_o = req[gnt].wen;
    assign m_adr_o = req[gnt].adr;
    assign m_ben_o = req[gnt].ben;
    assign m_wdt_o = req[gnt].wdt;
    assign xfer    = m_vld_o & m_rdy_i;

    always_comb begin
        lck_vld_d = lck_vld_q;
        lck_sel_d = lck_sel_q;
        ptr_d     = ptr_q;
        rsp_vld_d = xfer;
        rsp_sel_d = rsp_sel_q;
        if (xfer) begin
            lck_vld_d = 1'b0;
            ptr_d     = ~gnt;
            rsp_sel_d = gnt;
        end else if (m_vld_o) begin
            lck_vld_d = 1'b1;
            lck_sel_d = gnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lck_vld_q <= 1'b0;
            lck_sel_q <= 1'b0;
            ptr_q     <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_sel_q <= 1'b0;
        end else begin
            lck_vld_q <= lck_vld_d;
            lck_sel_q <= lck_sel_d;
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sel_q <= rsp_sel_d;
        end
    end

    // Steering uses the registered owner, never the current grant.
    for (genvar n = 0; n < NUM_REQ; n++) begin : g_port
        r5p_tcl_arbiter_port #(.IDX(n)) u_port (
            .rst_i    (rst_i),
            .gnt_i    (gnt),
            .m_rdy_i  (m_rdy_i),
            .m_err_i  (m_err_i),
            .rsp_vld_i(rsp_vld_q),
            .rsp_sel_i(rsp_sel_q),
            .rdy_o    (rdy_w[n]),
            .err_o    (err_w[n])
        );
    end

    assign s0_rdy_o = rdy_w[0];
    assign s1_rdy_o = rdy_w[1];
    assign s0_err_o = err_w[0];
    assign s1_err_o = err_w[1];
    assign s0_rdt_o = m_rdt_i;
    assign s1_rdt_o = m_rdt_i;
endmodule

// File: tb/tb_r5p_tcl_arbiter.sv
// Bench for r5p_tcl_arbiter: a fixed-priority and a round-robin instance, each checked
// against a behavioural model of grant ownership, stall ownership and response ownership.

module tb_r5p_tcl_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index [k][n]: k = instance (ARB_RR=k), n = requester
    logic        vld [2][2];
    logic        wen [2][2];
    logic [31:0] adr [2][2];
    logic [3:0]  ben [2][2];
    logic [31:0] wdt [2][2];
    logic [31:0] rdt [2][2];
    logic        err [2][2];
    logic        rdy [2][2];
    logic        m_vld [2];
    logic        m_wen [2];
    logic [31:0] m_adr [2];
    logic [3:0]  m_ben [2];
    logic [31:0] m_wdt [2];
    logic [31:0] m_rdt [2];
    logic        m_err [2];
    logic        m_rdy [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        r5p_tcl_arbiter #(.ARB_RR(k[0])) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .s0_vld_i(vld[k][0]), .s0_wen_i(wen[k][0]), .s0_adr_i(adr[k][0]),
            .s0_ben_i(ben[k][0]), .s0_wdt_i(wdt[k][0]),
            .s0_rdt_o(rdt[k][0]), .s0_err_o(err[k][0]), .s0_rdy_o(rdy[k][0]),
            .s1_vld_i(vld[k][1]), .s1_wen_i(wen[k][1]), .s1_adr_i(adr[k][1]),
            .s1_ben_i(ben[k][1]), .s1_wdt_i(wdt[k][1]),
            .s1_rdt_o(rdt[k][1]), .s1_err_o(err[k][1]), .s1_rdy_o(rdy[k][1]),
            .m_vld_o (m_vld[k]), .m_wen_o(m_wen[k]), .m_adr_o(m_adr[k]),
            .m_ben_o (m_ben[k]), .m_wdt_o(m_wdt[k]),
            .m_rdt_i (m_rdt[k]), .m_err_i(m_err[k]), .m_rdy_i(m_rdy[k])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Model: who was served last, who owns a stalled request (-1 none),
    // who owns the response due this cycle (-1 none).
    int last_srv [2];
    int stall_own[2];
    int rsp_own  [2];
    logic served [2][2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_srv[k]  = 1;
            stall_own[k] = -1;
            rsp_own[k]   = -1;
        end
    endtask

    task automatic step();
        int g [2];
        logic mv [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (stall_own[k] >= 0)              g[k] = stall_own[k];
            else if (vld[k][0] && !vld[k][1])   g[k] = 0;
            else if (vld[k][1] && !vld[k][0])   g[k] = 1;
            else if (vld[k][0] && vld[k][1])    g[k] = (k == 1) ? 1 - last_srv[k] : 0;
            else                                g[k] = 1 - last_srv[k];
            mv[k] = !rst && vld[k][g[k]];
            if (stall_own[k] >= 0 && !rst)
                assert (vld[k][stall_own[k]]) else $error("stalled owner dropped vld inst%0d", k);
            chk($sformatf("m_vld%0d", k), m_vld[k], mv[k]);
            if (mv[k])
                chk($sformatf("m_req%0d", k), {m_wen[k], m_ben[k], m_adr[k], m_wdt[k]},
                    {wen[k][g[k]], ben[k][g[k]], adr[k][g[k]], wdt[k][g[k]]});
            for (int n = 0; n < 2; n++) begin
                if (rst || mv[k])
                    chk($sformatf("rdy%0d_%0d", k, n), rdy[k][n], !rst && m_rdy[k] && g[k] == n);
                chk($sformatf("err%0d_%0d", k, n), err[k][n], !rst && m_err[k] && rsp_own[k] == n);
                chk($sformatf("rdt%0d_%0d", k, n), rdt[k][n], m_rdt[k]);
                served[k][n] = mv[k] && m_rdy[k] && g[k] == n;
            end
        end
        @(posedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) begin
            rsp_own[k] = (mv[k] && m_rdy[k]) ? g[k] : -1;
            if (mv[k] && m_rdy[k]) begin
                last_srv[k]  = g[k];
                stall_own[k] = -1;
            end else if (mv[k]) stall_own[k] = g[k];
        end
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a);
        for (int k = 0; k < 2; k++) begin
            vld[k][n] = v;
            wen[k][n] = a[2];
            adr[k][n] = a;
            ben[k][n] = a[7:4];
            wdt[k][n] = ~a;
        end
    endtask

    task automatic set_mgr(input logic r, input logic e, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            m_rdy[k] = r;
            m_err[k] = e;
            m_rdt[k] = d;
        end
    endtask

    task automatic rand_req(input int k, input int n);
        vld[k][n] = ($urandom_range(0, 99) < 60);
        wen[k][n] = 1'($urandom);
        adr[k][n] = $urandom;
        ben[k][n] = 4'($urandom);
        wdt[k][n] = $urandom;
    endtask

    initial begin
        model_reset();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0);
        set_mgr(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // Single requester read, data returned next cycle
        set_req(0, 1'b1, 32'h0000_0010);
        set_mgr(1'b1, 1'b0, 32'h0);
        step();
        set_req(0, 1'b0, 32'h0);
        set_mgr(1'b0, 1'b0, 32'hDEAD_BEEF);
        step();

        // Contention from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        set_mgr(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 32'h100 + 32'(c));
            set_req(1, 1'b1, 32'h200);
            step();
        end
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0);
        step();

        // Stall lock on s1, s0 arrives mid-stall
        set_mgr(1'b0, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h300);
        step();
        set_req(0, 1'b1, 32'h340);
        step(); step();
        set_mgr(1'b1, 1'b0, 32'h0);
        step();
        set_req(1, 1'b0, 32'h0);
        step();
        set_req(0, 1'b0, 32'h0);
        step();

        // Response for s0 coincides with grant to s1
        set_req(0, 1'b1, 32'h400);
        step();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h480);
        set_mgr(1'b1, 1'b1, 32'h1234_5678);
        step();
        set_req(1, 1'b0, 32'h0);
        set_mgr(1'b1, 1'b0, 32'h0);
        step();

        // Reset during a stall
        set_mgr(1'b0, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h500);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        set_req(0, 1'b1, 32'h540);
        set_mgr(1'b1, 1'b1, 32'h0);
        step();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0);
        set_mgr(1'b0, 1'b0, 32'h0);
        step();

        // Random traffic; requesters honour hold-until-ready
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int k = 0; k < 2; k++) begin
                m_rdy[k] = ($urandom_range(0, 99) < 65);
                m_err[k] = ($urandom_range(0, 99) < 30);
                m_rdt[k] = $urandom;
                for (int n = 0; n < 2; n++)
                    if (!vld[k][n] || served[k][n]) rand_req(k, n);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
